// File: rtl/deser32.sv
`default_nettype none
// ============================================================================
// Module   : deser32
// Brief    : Bit-serial to WIDTH-bit parallel word assembler with a
//            valid/ready handshake on both sides. An optional trailing
//            even-parity bit per word is enabled by defining DESER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module deser32 #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [4:0]       s
`ifdef DESER_PARITY_EN
   ,
   output logic             o_perr
`endif
);

   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDXW-1:0] c_start_idx = MSB_FIRST ? IDXW'(WIDTH-1) : '0;
   localparam logic [IDXW-1:0] c_end_idx   = MSB_FIRST ? '0 : IDXW'(WIDTH-1);
   localparam logic [IDXW-1:0] c_step      = IDXW'(1);

   localparam logic [0:0] c_st_fill = 1'b0;
   localparam logic [0:0] c_st_full = 1'b1;

   logic [0:0]       r_state;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] w_word;
   logic             w_in_xfer;
   logic             w_last;

`ifdef DESER_PARITY_EN
   logic r_par_slot;
   logic r_perr;

   // The parity slot follows the end-index data bit; the index parks there meanwhile.
   assign w_last = r_par_slot;
   assign o_perr = r_perr;
`else
   assign w_last = (r_idx == c_end_idx);
`endif

   assign o_valid   = (r_state == c_st_full);
   assign i_ready   = !o_valid | o_ready;
   assign w_in_xfer = i_valid & i_ready;
   assign s         = 5'(r_idx);

   always_comb begin
      w_word        = r_shadow;
      w_word[r_idx] = i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= c_st_fill;
         r_idx    <= c_start_idx;
         r_shadow <= '0;
         o        <= '0;
`ifdef DESER_PARITY_EN
         r_par_slot <= 1'b0;
         r_perr     <= 1'b0;
`endif
      end else begin
         if (o_valid && o_ready) begin
            r_state <= c_st_fill;
         end

         if (flush) begin
            r_shadow <= '0;
            r_idx    <= c_start_idx;
`ifdef DESER_PARITY_EN
            r_par_slot <= 1'b0;
`endif
         end else if (w_in_xfer) begin
            if (w_last) begin
               r_state  <= c_st_full;
               r_idx    <= c_start_idx;
               r_shadow <= '0;
`ifdef DESER_PARITY_EN
               o          <= r_shadow;
               r_perr     <= (^r_shadow) ^ i;
               r_par_slot <= 1'b0;
`else
               o <= w_word;
`endif
            end else begin
               r_shadow <= w_word;
`ifdef DESER_PARITY_EN
               if (r_idx == c_end_idx) begin
                  r_par_slot <= 1'b1;
               end else begin
                  r_idx <= MSB_FIRST ? (r_idx - c_step) : (r_idx + c_step);
               end
`else
               r_idx <= MSB_FIRST ? (r_idx - c_step) : (r_idx + c_step);
`endif
            end
         end
      end
   end

endmodule
`default_nettype wire
